// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
//   Two-master arbiter in front of one pipelined Wishbone slave. m0 is the
//   instruction-fetch master, m1 the load/store master. A master keeps the bus
//   for its whole cycle (cyc high). The grant is released only once every
//   accepted request has been acked, so late acks still reach their owner.
//
// Parameters
//   ROUND_ROBIN      1: alternate on a tie, 0: m0 always wins a tie
//   MAX_OUTSTANDING  accepted-but-unacked requests allowed per grant (>=1)
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   m{0,1}_wb_*_i            master requests (adr, dat, sel, we, stb, cyc)
//   m{0,1}_wb_dat_o          read data, same slave data to both masters
//   m{0,1}_wb_ack_o          ack, only to the granted master
//   m{0,1}_wb_stall_o        stall, always high for the non-granted master
//   s_wb_*_o                 request muxed from the granted master
//   s_wb_dat_i/ack_i/stall_i slave response

module wishbone_arbiter #(
  parameter int ROUND_ROBIN     = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic [31:0] m0_wb_dat_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,
  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic [31:0] m1_wb_dat_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,
  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic [31:0] s_wb_dat_i,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i
);

  localparam int CW = (MAX_OUTSTANDING < 1) ? 1 : $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;   // master that released most recently
  logic          full;
  logic          accept;
  logic          ack_cnt;

  assign full    = (cnt_q == CW'(MAX_OUTSTANDING));
  assign accept  = s_wb_stb_o & ~s_wb_stall_i;
  // Acks are only counted while a master owns the bus; stray acks in IDLE
  // (e.g. in flight across a reset) are dropped.
  assign ack_cnt = s_wb_ack_i & (state_q != IDLE);

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;   // m1 counts as last so m0 wins the first tie
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    // Simultaneous accept and ack cancel; an ack with nothing pending is ignored.
    if (accept && !ack_cnt) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!accept && ack_cnt && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d = (ROUND_ROBIN != 0 && last_q == 1'b0) ? GNT1 : GNT0;
        end else if (m0_wb_cyc_i) begin
          state_d = GNT0;
        end else if (m1_wb_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        // Release uses the post-update count so the final ack frees the bus.
        if (!m0_wb_cyc_i && cnt_d == '0) begin
          last_d  = 1'b0;
          state_d = m1_wb_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_wb_cyc_i && cnt_d == '0) begin
          last_d  = 1'b1;
          state_d = m0_wb_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_sel_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_ack_o   = 1'b0;
    m1_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_stall_o = 1'b1;

    unique case (state_q)
      GNT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_we_o     = m0_wb_we_i;
        // cyc stays up while acks are pending even if the master let go
        s_wb_cyc_o    = m0_wb_cyc_i | (cnt_q != '0);
        s_wb_stb_o    = m0_wb_stb_i & ~full;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i | full;
      end
      GNT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_cyc_o    = m1_wb_cyc_i | (cnt_q != '0);
        s_wb_stb_o    = m1_wb_stb_i & ~full;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i | full;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0, s_dat = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic        m0_we = 0, m0_stb = 0, m0_cyc = 0;
  logic        m1_we = 0, m1_stb = 0, m1_cyc = 0;
  logic        s_ack = 0, s_stall = 0;

  int n_cmp = 0;
  int n_bad = 0;

  // outputs of the round-robin instance (rr_) and fixed-priority instance (fp_)
  logic [31:0] rr_m0_dat, rr_m1_dat, rr_s_adr, rr_s_dat;
  logic [3:0]  rr_s_sel;
  logic        rr_m0_ack, rr_m0_stall, rr_m1_ack, rr_m1_stall;
  logic        rr_s_we, rr_s_stb, rr_s_cyc;
  logic [31:0] fp_m0_dat, fp_m1_dat, fp_s_adr, fp_s_dat;
  logic [3:0]  fp_s_sel;
  logic        fp_m0_ack, fp_m0_stall, fp_m1_ack, fp_m1_stall;
  logic        fp_s_we, fp_s_stb, fp_s_cyc;

  wishbone_arbiter #(.ROUND_ROBIN(1), .MAX_OUTSTANDING(MAXO)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_we_i(m0_we), .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
    .m0_wb_dat_o(rr_m0_dat), .m0_wb_ack_o(rr_m0_ack), .m0_wb_stall_o(rr_m0_stall),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_we_i(m1_we), .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
    .m1_wb_dat_o(rr_m1_dat), .m1_wb_ack_o(rr_m1_ack), .m1_wb_stall_o(rr_m1_stall),
    .s_wb_adr_o(rr_s_adr), .s_wb_dat_o(rr_s_dat), .s_wb_sel_o(rr_s_sel),
    .s_wb_we_o(rr_s_we), .s_wb_stb_o(rr_s_stb), .s_wb_cyc_o(rr_s_cyc),
    .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall)
  );

  wishbone_arbiter #(.ROUND_ROBIN(0), .MAX_OUTSTANDING(MAXO)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_we_i(m0_we), .m0_wb_stb_i(m0_stb), .m0_wb_cyc_i(m0_cyc),
    .m0_wb_dat_o(fp_m0_dat), .m0_wb_ack_o(fp_m0_ack), .m0_wb_stall_o(fp_m0_stall),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_we_i(m1_we), .m1_wb_stb_i(m1_stb), .m1_wb_cyc_i(m1_cyc),
    .m1_wb_dat_o(fp_m1_dat), .m1_wb_ack_o(fp_m1_ack), .m1_wb_stall_o(fp_m1_stall),
    .s_wb_adr_o(fp_s_adr), .s_wb_dat_o(fp_s_dat), .s_wb_sel_o(fp_s_sel),
    .s_wb_we_o(fp_s_we), .s_wb_stb_o(fp_s_stb), .s_wb_cyc_o(fp_s_cyc),
    .s_wb_dat_i(s_dat), .s_wb_ack_i(s_ack), .s_wb_stall_i(s_stall)
  );

  typedef struct packed {
    logic        cyc, stb;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, ack0, ack1, st0, st1;
    logic [31:0] d0, d1;
  } obs_t;

  obs_t obs_rr, obs_fp;
  assign obs_rr = {rr_s_cyc, rr_s_stb, rr_s_adr, rr_s_dat, rr_s_sel, rr_s_we,
                   rr_m0_ack, rr_m1_ack, rr_m0_stall, rr_m1_stall, rr_m0_dat, rr_m1_dat};
  assign obs_fp = {fp_s_cyc, fp_s_stb, fp_s_adr, fp_s_dat, fp_s_sel, fp_s_we,
                   fp_m0_ack, fp_m1_ack, fp_m0_stall, fp_m1_stall, fp_m0_dat, fp_m1_dat};

  // Reference model: who owns the bus (-1 none), how many requests are
  // outstanding, and who released last.
  typedef struct { int owner; int outst; int last; } mst_t;
  mst_t ms_rr, ms_fp;

  function automatic obs_t model_out(mst_t st);
    obs_t o;
    bit   full;
    o = '0;
    o.st0 = 1'b1; o.st1 = 1'b1;
    o.d0 = s_dat; o.d1 = s_dat;
    full = (st.outst == MAXO);
    if (st.owner == 0) begin
      o.adr = m0_adr; o.dat = m0_dat; o.sel = m0_sel; o.we = m0_we;
      o.cyc = m0_cyc || (st.outst > 0);
      o.stb = m0_stb && !full;
      o.ack0 = s_ack; o.st0 = s_stall || full;
    end else if (st.owner == 1) begin
      o.adr = m1_adr; o.dat = m1_dat; o.sel = m1_sel; o.we = m1_we;
      o.cyc = m1_cyc || (st.outst > 0);
      o.stb = m1_stb && !full;
      o.ack1 = s_ack; o.st1 = s_stall || full;
    end
    return o;
  endfunction

  function automatic mst_t model_next(mst_t st, bit rr);
    mst_t n;
    obs_t o;
    bit   acc, kc, oc;
    n = st;
    if (st.owner < 0) begin
      if (m0_cyc && m1_cyc) n.owner = (rr && st.last == 0) ? 1 : 0;
      else if (m0_cyc)      n.owner = 0;
      else if (m1_cyc)      n.owner = 1;
    end else begin
      o   = model_out(st);
      acc = o.stb && !s_stall;
      if (acc && !s_ack) n.outst = st.outst + 1;
      else if (!acc && s_ack && st.outst > 0) n.outst = st.outst - 1;
      kc = (st.owner == 0) ? m0_cyc : m1_cyc;
      oc = (st.owner == 0) ? m1_cyc : m0_cyc;
      if (!kc && n.outst == 0) begin
        n.last  = st.owner;
        n.owner = oc ? 1 - st.owner : -1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms_rr <= '{-1, 0, 1};
      ms_fp <= '{-1, 0, 1};
    end else begin
      ms_rr <= model_next(ms_rr, 1'b1);
      ms_fp <= model_next(ms_fp, 1'b0);
    end
  end

  task automatic check_obs(string nm, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  bit sb_en = 1'b0;
  always @(negedge clk) begin
    if (sb_en) begin
      check_obs("model_rr", obs_rr, model_out(ms_rr));
      check_obs("model_fp", obs_fp, model_out(ms_fp));
    end
  end

  // Directed vector table, checked against the round-robin instance.
  typedef struct {
    logic        c0, s0; logic [31:0] a0;
    logic        c1, s1; logic [31:0] a1;
    logic        ack, stl; logic [31:0] sd;
    logic        ecyc, estb; logic [31:0] eadr;
    logic        ea0, ea1, es0, es1;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic c0, s0, input logic [31:0] a0,
                     input logic c1, s1, input logic [31:0] a1,
                     input logic ack, stl, input logic [31:0] sd,
                     input logic ecyc, estb, input logic [31:0] eadr,
                     input logic ea0, ea1, es0, es1);
    tbl.push_back('{c0, s0, a0, c1, s1, a1, ack, stl, sd,
                    ecyc, estb, eadr, ea0, ea1, es0, es1});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0; s_stall = 0;
  endtask

  initial begin
    logic [102:0] act, exp;

    // both cyc after reset -> m0; m0 drops -> m1 directly with 0x100
    add(1,0,32'h40, 1,1,32'h100, 0,0,32'h0,  0,0,32'h0,   0,0,1,1);
    add(1,0,32'h40, 1,1,32'h100, 0,0,32'h0,  1,0,32'h40,  0,0,0,1);
    add(0,0,32'h40, 1,1,32'h100, 0,0,32'h0,  0,0,32'h40,  0,0,0,1);
    add(0,0,32'h40, 1,1,32'h100, 0,0,32'h0,  1,1,32'h100, 0,0,1,0);
    add(0,0,32'h40, 1,0,32'h100, 1,0,32'h55, 1,0,32'h100, 0,1,1,0);
    add(0,0,32'h40, 0,0,32'h100, 0,0,32'h0,  0,0,32'h100, 0,0,1,0);
    // m0 alone: three pipelined reads, acks one cycle behind
    add(1,1,32'h0, 0,0,32'h0, 0,0,32'h0,  0,0,32'h0, 0,0,1,1);
    add(1,1,32'h0, 0,0,32'h0, 0,0,32'h0,  1,1,32'h0, 0,0,0,1);
    add(1,1,32'h4, 0,0,32'h0, 1,0,32'hA0, 1,1,32'h4, 1,0,0,1);
    add(1,1,32'h8, 0,0,32'h0, 1,0,32'hA1, 1,1,32'h8, 1,0,0,1);
    add(1,0,32'h8, 0,0,32'h0, 1,0,32'hA2, 1,0,32'h8, 1,0,0,1);
    add(0,0,32'h8, 0,0,32'h0, 0,0,32'h0,  0,0,32'h8, 0,0,0,1);
    add(0,0,32'h8, 0,0,32'h0, 0,0,32'h0,  0,0,32'h0, 0,0,1,1);

    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    sb_en = 1'b1;

    // reset while m0 holds the bus with a request outstanding
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h600;
    step(); step(); m0_stb = 0;
    @(negedge clk);
    chk("rst_pre_cyc", 32'(rr_s_cyc), 32'd1);
    step();
    rst_n = 1'b0; s_ack = 1;
    #1;
    chk("rst_cyc_rr", 32'(rr_s_cyc), 32'd0);
    chk("rst_cyc_fp", 32'(fp_s_cyc), 32'd0);
    chk("rst_stall", {30'd0, rr_m0_stall, rr_m1_stall}, 32'd3);
    step(); step();
    m0_cyc = 0; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_late_ack", 32'(rr_m0_ack), 32'd0);
    chk("rst_late_cyc", 32'(rr_s_cyc), 32'd0);
    step(); clear_in();
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      step();
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0; m0_adr = tbl[i].a0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; m1_adr = tbl[i].a1;
      s_ack = tbl[i].ack; s_stall = tbl[i].stl; s_dat = tbl[i].sd;
      @(negedge clk);
      act = {rr_s_cyc, rr_s_stb, rr_s_adr, rr_m0_ack, rr_m1_ack,
             rr_m0_stall, rr_m1_stall, rr_m0_dat, rr_m1_dat};
      exp = {tbl[i].ecyc, tbl[i].estb, tbl[i].eadr, tbl[i].ea0, tbl[i].ea1,
             tbl[i].es0, tbl[i].es1, tbl[i].sd, tbl[i].sd};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d actual=%h required=%h", i, act, exp);
      end
    end

    // outstanding limit: slave never acks until released by hand
    step(); clear_in(); m0_cyc = 1; m0_stb = 1; m0_adr = 32'h200;
    step(); step(); step();
    s_ack = 1;
    @(negedge clk);
    chk("full_stall", 32'(rr_m0_stall), 32'd1);
    chk("full_stb", 32'(rr_s_stb), 32'd0);
    step(); s_ack = 0;
    @(negedge clk);
    chk("third_stb", 32'(rr_s_stb), 32'd1);
    chk("third_nostall", 32'(rr_m0_stall), 32'd0);
    step();
    @(negedge clk);
    chk("full_again", 32'(rr_m0_stall), 32'd1);
    step(); m0_cyc = 0; m0_stb = 0; s_ack = 1;
    @(negedge clk);
    chk("drain_cyc", 32'(rr_s_cyc), 32'd1);
    step();
    step(); s_ack = 0;
    @(negedge clk);
    chk("drained_idle", 32'(rr_s_cyc), 32'd0);

    // m1 drops cyc with two outstanding
    step(); m1_cyc = 1; m1_stb = 1; m1_adr = 32'h300;
    step(); step();
    step(); m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    chk("m1_hold0", 32'(rr_s_cyc), 32'd1);
    step(); s_ack = 1;
    @(negedge clk);
    chk("m1_hold1", 32'(rr_s_cyc), 32'd1);
    chk("m1_ack_fwd", {30'd0, rr_m1_ack, rr_m0_ack}, 32'd2);
    step(); s_ack = 0;
    @(negedge clk);
    chk("m1_hold2", 32'(rr_s_cyc), 32'd1);
    step(); s_ack = 1;
    @(negedge clk);
    chk("m1_hold3", 32'(rr_s_cyc), 32'd1);
    step(); s_ack = 0;
    @(negedge clk);
    chk("m1_released", 32'(rr_s_cyc), 32'd0);
    chk("m1_rel_stall", 32'(rr_m1_stall), 32'd1);

    // tie after an m0 release: fixed priority keeps m0, round robin gives m1
    step(); m0_cyc = 1;
    step();
    step(); m0_cyc = 0;
    step();
    step(); m0_cyc = 1; m1_cyc = 1; m0_adr = 32'h400; m1_adr = 32'h500;
    step();
    @(negedge clk);
    chk("tie_fp_adr", fp_s_adr, 32'h400);
    chk("tie_rr_adr", rr_s_adr, 32'h500);
    chk("tie_rr_stall0", 32'(rr_m0_stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("fp_m1_wait", 32'(fp_m1_stall), 32'd1);
    end
    step(); m0_cyc = 0;
    step(); m0_cyc = 1;
    @(negedge clk);
    chk("fp_handoff_adr", fp_s_adr, 32'h500);
    chk("fp_handoff_stall0", 32'(fp_m0_stall), 32'd1);
    step(); m1_cyc = 0;
    step();
    @(negedge clk);
    chk("fp_back_m0", fp_s_adr, 32'h400);
    chk("rr_back_m0", rr_s_adr, 32'h400);
    step(); clear_in();
    step();

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 500; i++) begin
      step();
      if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
      m0_stb  = m0_cyc & $urandom_range(0, 1);
      m1_stb  = m1_cyc & $urandom_range(0, 1);
      m0_adr  = $urandom; m1_adr = $urandom;
      m0_dat  = $urandom; m1_dat = $urandom;
      m0_sel  = 4'($urandom); m1_sel = 4'($urandom);
      m0_we   = 1'($urandom); m1_we = 1'($urandom);
      s_ack   = ($urandom_range(0, 2) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_dat   = $urandom;
    end
    step(); clear_in(); s_ack = 1;
    repeat (8) step();
    s_ack = 0;
    step();
    @(negedge clk);
    chk("end_idle_rr", 32'(rr_s_cyc), 32'd0);
    chk("end_idle_fp", 32'(fp_s_cyc), 32'd0);
    sb_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
